// File: rtl/line_seg_queue_pkg.sv
// Shared line-segment definitions used by the AVG core, this queue and the rasterizer.
package line_q_pkg;

  // Default field widths of a line segment
  localparam int LQ_COORD_W = 13;
  localparam int LQ_INT_W   = 4;

  // One line segment as exchanged between vector generator and rasterizer
  typedef struct packed {
    logic [LQ_COORD_W-1:0] start_x;
    logic [LQ_COORD_W-1:0] start_y;
    logic [LQ_COORD_W-1:0] end_x;
    logic [LQ_COORD_W-1:0] end_y;
    logic [LQ_INT_W-1:0]   intensity;
    logic                  eof;
  } line_seg_t;

  // A blank segment draws nothing and carries no frame boundary
  function automatic logic lq_is_blank(input line_seg_t seg);
    return (seg.intensity == '0) && !seg.eof;
  endfunction

endpackage

// File: rtl/line_seg_queue_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count increment requests, sticking at the maximum value
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/line_seg_queue.sv
// Line-segment FIFO between the AVG core and the rasterizer.
// First-word-fall-through read, registered occupancy flags, end-of-frame
// tracking, optional blank filtering, flush and a saturating drop counter.
module line_seg_queue
  import line_q_pkg::*;
#(
  parameter int COORD_W    = 13,
  parameter int INT_W      = 4,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  parameter int SKIP_BLANK = 1,
  parameter int OVF_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [COORD_W-1:0]         wr_start_x,
  input  logic [COORD_W-1:0]         wr_start_y,
  input  logic [COORD_W-1:0]         wr_end_x,
  input  logic [COORD_W-1:0]         wr_end_y,
  input  logic [INT_W-1:0]           wr_intensity,
  input  logic                       wr_eof,
  input  logic                       rd_en,
  output logic [COORD_W-1:0]         rd_start_x,
  output logic [COORD_W-1:0]         rd_start_y,
  output logic [COORD_W-1:0]         rd_end_x,
  output logic [COORD_W-1:0]         rd_end_y,
  output logic [INT_W-1:0]           rd_intensity,
  output logic                       rd_eof,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     frames_pending,
  input  logic                       flush,
  output logic [OVF_W-1:0]           overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 4 * COORD_W + INT_W + 1;

  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_next;
  logic [CW-1:0]      frames_next;
  logic [EW-1:0]      head;
  logic               blank;
  logic               filtered;
  logic               wr_accept;
  logic               pop;
  logic               overflow_hit;

  // Blank detection uses the shared helper when the fields match the package layout
  if (COORD_W == LQ_COORD_W && INT_W == LQ_INT_W) begin : g_pkg_blank
    line_seg_t wr_seg;
    assign wr_seg = '{start_x:   wr_start_x,
                      start_y:   wr_start_y,
                      end_x:     wr_end_x,
                      end_y:     wr_end_y,
                      intensity: wr_intensity,
                      eof:       wr_eof};
    assign blank = lq_is_blank(wr_seg);
  end else begin : g_local_blank
    assign blank = (wr_intensity == '0) && !wr_eof;
  end

  assign filtered     = (SKIP_BLANK != 0) && blank;
  assign wr_accept    = wr_en && !flush && !filtered && (!full || rd_en);
  assign pop          = rd_en && !empty && !flush;
  assign overflow_hit = wr_en && !filtered && !flush && full && !rd_en;

  // Head entry falls through to the outputs; zeroed while nothing is stored
  assign head         = mem[rd_ptr];
  assign rd_start_x   = empty ? '0 : head[EW-1 -: COORD_W];
  assign rd_start_y   = empty ? '0 : head[EW-1-COORD_W -: COORD_W];
  assign rd_end_x     = empty ? '0 : head[EW-1-2*COORD_W -: COORD_W];
  assign rd_end_y     = empty ? '0 : head[EW-1-3*COORD_W -: COORD_W];
  assign rd_intensity = empty ? '0 : head[INT_W:1];
  assign rd_eof       = empty ? 1'b0 : head[0];

  // Next occupancy and frame count; flush wins over any concurrent traffic
  always_comb begin
    count_next  = count;
    frames_next = frames_pending;
    if (flush) begin
      count_next  = '0;
      frames_next = '0;
    end else begin
      if (wr_accept && !pop) begin
        count_next = count + 1'b1;
      end else if (pop && !wr_accept) begin
        count_next = count - 1'b1;
      end
      if ((wr_accept && wr_eof) && !(pop && head[0])) begin
        frames_next = frames_pending + 1'b1;
      end else if ((pop && head[0]) && !(wr_accept && wr_eof)) begin
        frames_next = frames_pending - 1'b1;
      end
    end
  end

  // Storage array is written only on accepted writes and needs no reset
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= {wr_start_x, wr_start_y, wr_end_x, wr_end_y, wr_intensity, wr_eof};
    end
  end

  // Pointers, occupancy and flags move together so the flags always match count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      frames_pending <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      almost_full    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
      count          <= count_next;
      frames_pending <= frames_next;
      empty          <= (count_next == '0);
      full           <= (count_next == FULL_LEVEL);
      almost_full    <= (count_next >= AF_LEVEL);
    end
  end

  sat_counter #(.W(OVF_W)) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (overflow_hit),
    .value (overflow_cnt)
  );

endmodule
